// File: rtl/alu_result_stage_if.sv
// ----------------------------------------------------------------------------
// alu_result_stage_if
// Bundles the two valid/ready links of the ALU result stage.
//
// Handshake rule for both links: a transfer happens on a rising clock edge
// where valid and ready are both 1. The sender holds its payload stable while
// valid=1 and ready=0. Ready never depends combinationally on valid.
//
//   in_*  : producer (ALU) -> stage.  in_valid/in_op/in_s/in_c/in_zero/
//           in_overflow from the producer, in_ready back to it.
//   out_* : stage -> consumer.  out_valid/out_op/out_s/out_c/out_zero/
//           out_overflow from the stage, out_ready back from the consumer.
//
// Modports:
//   master : the environment side (drives in_*, out_ready).
//   slave  : the stage itself.
// ----------------------------------------------------------------------------
interface alu_result_stage_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_s;
    logic             in_c;
    logic             in_zero;
    logic             in_overflow;

    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_op;
    logic [WIDTH-1:0] out_s;
    logic             out_c;
    logic             out_zero;
    logic             out_overflow;

    modport master (
        output in_valid, in_op, in_s, in_c, in_zero, in_overflow, out_ready,
        input  in_ready, out_valid, out_op, out_s, out_c, out_zero, out_overflow
    );

    modport slave (
        input  in_valid, in_op, in_s, in_c, in_zero, in_overflow, out_ready,
        output in_ready, out_valid, out_op, out_s, out_c, out_zero, out_overflow
    );
endinterface

// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
// Captures ALU results into a DEPTH-entry circular FIFO and hands them to a
// possibly stalling consumer over valid/ready. Keeps sticky carry/overflow
// status flags.
//
// Ports:
//   clk           : clock, all state changes on the rising edge
//   rst           : synchronous active-high reset
//   bus           : alu_result_stage_if.slave (in_* producer link,
//                   out_* consumer link)
//   clr_sticky    : clears sticky_c / sticky_ov / zero_mismatch
//   count         : FIFO occupancy, 0..DEPTH
//   sticky_c      : some accepted entry carried since last clear
//   sticky_ov     : some accepted entry overflowed since last clear
//   zero_mismatch : some accepted entry had a wrong zero flag (only with
//                   ALU_RESULT_ZERO_CHECK_EN, otherwise tied to 0)
//
// Build option: define ALU_RESULT_ZERO_CHECK_EN to recompute the zero flag on
// every push, store the recomputed value and flag disagreements.
// ----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    alu_result_stage_if.slave          bus,
    input  logic                       clr_sticky,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       sticky_c,
    output logic                       sticky_ov,
    output logic                       zero_mismatch
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    // Entry layout: {op[2:0], s[WIDTH-1:0], c, zero, overflow}
    localparam int EW = 3 + WIDTH + 3;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_sticky_c;
    logic          r_sticky_ov;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_zero_store;
    logic [EW-1:0] w_head;

    // Both flags come from the registered count only, so in_ready has no
    // path from out_ready: a full FIFO refuses a push even while popping.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = !w_empty && bus.out_ready;

`ifdef ALU_RESULT_ZERO_CHECK_EN
    logic w_zero_calc;
    logic r_zero_mismatch;

    assign w_zero_calc  = (bus.in_s == '0);
    assign w_zero_store = w_zero_calc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero_mismatch <= 1'b0;
        end else if (clr_sticky) begin
            // A mismatch arriving with the clear still gets recorded.
            r_zero_mismatch <= w_push && (w_zero_calc != bus.in_zero);
        end else if (w_push && (w_zero_calc != bus.in_zero)) begin
            r_zero_mismatch <= 1'b1;
        end
    end

    assign zero_mismatch = r_zero_mismatch;
`else
    assign w_zero_store  = bus.in_zero;
    assign zero_mismatch = 1'b0;
`endif

    // Storage is intentionally not reset; out_* are don't-care when empty.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_op, bus.in_s, bus.in_c, w_zero_store,
                                bus.in_overflow};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky flags: clear has lower priority than a set in the same cycle,
    // so with clr_sticky the flag takes the value of the new entry's flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky_c  <= 1'b0;
            r_sticky_ov <= 1'b0;
        end else if (clr_sticky) begin
            r_sticky_c  <= w_push && bus.in_c;
            r_sticky_ov <= w_push && bus.in_overflow;
        end else begin
            r_sticky_c  <= r_sticky_c  || (w_push && bus.in_c);
            r_sticky_ov <= r_sticky_ov || (w_push && bus.in_overflow);
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign bus.in_ready     = !w_full;
    assign bus.out_valid    = !w_empty;
    assign bus.out_op       = w_head[EW-1 -: 3];
    assign bus.out_s        = w_head[WIDTH+2:3];
    assign bus.out_c        = w_head[2];
    assign bus.out_zero     = w_head[1];
    assign bus.out_overflow = w_head[0];

    assign count     = r_count;
    assign sticky_c  = r_sticky_c;
    assign sticky_ov = r_sticky_ov;
endmodule

// File: tb/tb_alu_result_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_result_stage
// Table-driven bench for alu_result_stage (WIDTH=4, DEPTH=4). Each table row
// is one clock cycle of stimulus plus the count/sticky values expected after
// that edge. A reference model (queue of expected entries, occupancy and
// sticky flags) checks every handshake and every popped entry. A random phase
// follows the table.
// ----------------------------------------------------------------------------
module tb_alu_result_stage;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int EW    = 3 + WIDTH + 3;
`ifdef ALU_RESULT_ZERO_CHECK_EN
    localparam logic ZCHK = 1'b1;
`else
    localparam logic ZCHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          clr_sticky;
    logic [CW-1:0] count;
    logic          sticky_c;
    logic          sticky_ov;
    logic          zero_mismatch;

    always #5 clk = ~clk;

    alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .clr_sticky    (clr_sticky),
        .count         (count),
        .sticky_c      (sticky_c),
        .sticky_ov     (sticky_ov),
        .zero_mismatch (zero_mismatch)
    );

    // ---------------- scoreboard / model ----------------
    logic [EW-1:0] exp_q[$];
    logic          m_sc;
    logic          m_sov;
    logic          m_zm;
    int            total = 0;
    int            bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs (outputs are registered-only, so they can be
    // checked right after driving), compare against the model, then clock.
    task automatic step(input logic r, input logic iv, input logic [2:0] op,
                        input logic [3:0] s, input logic c, input logic z,
                        input logic ov, input logic ordy, input logic clr);
        logic          push;
        logic          pop;
        logic          zs;
        logic [EW-1:0] e;
        rst              = r;
        bus.in_valid     = iv;
        bus.in_op        = op;
        bus.in_s         = s;
        bus.in_c         = c;
        bus.in_zero      = z;
        bus.in_overflow  = ov;
        bus.out_ready    = ordy;
        clr_sticky       = clr;

        check("in_ready",  {31'd0, bus.in_ready},  {31'd0, exp_q.size() != DEPTH});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
        check("count",     {{(32-CW){1'b0}}, count}, exp_q.size());
        check("sticky_c",  {31'd0, sticky_c},  {31'd0, m_sc});
        check("sticky_ov", {31'd0, sticky_ov}, {31'd0, m_sov});
        check("zero_mismatch", {31'd0, zero_mismatch}, {31'd0, m_zm});

        push = iv && (exp_q.size() != DEPTH);
        pop  = ordy && (exp_q.size() != 0);

        if (r) begin
            exp_q.delete();
            m_sc  = 1'b0;
            m_sov = 1'b0;
            m_zm  = 1'b0;
        end else begin
            if (pop) begin
                e = exp_q.pop_front();
                check("head_entry",
                      {22'd0, bus.out_op, bus.out_s, bus.out_c, bus.out_zero, bus.out_overflow},
                      {22'd0, e});
            end
            zs = ZCHK ? (s == 4'd0) : z;
            if (push) exp_q.push_back({op, s, c, zs, ov});
            if (clr) begin
                m_sc  = push && c;
                m_sov = push && ov;
                m_zm  = ZCHK && push && ((s == 4'd0) != z);
            end else begin
                m_sc  = m_sc  || (push && c);
                m_sov = m_sov || (push && ov);
                m_zm  = m_zm  || (ZCHK && push && ((s == 4'd0) != z));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       iv;
        logic [2:0] op;
        logic [3:0] s;
        logic       c;
        logic       z;
        logic       ov;
        logic       ordy;
        logic       clr;
        int         exp_cnt;
        logic       exp_sc;
        logic       exp_sov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic iv, input logic [2:0] op,
                       input logic [3:0] s, input logic c, input logic z,
                       input logic ov, input logic ordy, input logic clr,
                       input int ec, input logic esc, input logic esov);
        vec_t v;
        v.rst = r;  v.iv = iv; v.op = op; v.s = s; v.c = c; v.z = z;
        v.ov = ov;  v.ordy = ordy; v.clr = clr;
        v.exp_cnt = ec; v.exp_sc = esc; v.exp_sov = esov;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] rs;
        logic       rz;
        m_sc = 1'b0; m_sov = 1'b0; m_zm = 1'b0;
        rst = 1'b1; clr_sticky = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_s = '0; bus.in_c = 1'b0;
        bus.in_zero = 1'b0; bus.in_overflow = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);

        //   rst iv op s     c  z  ov rdy clr  cnt sc sov
        // reset then idle
        add(1, 0, 0, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        add(1, 0, 0, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        // single transfer, held while stalled, then popped
        add(0, 1, 0, 4'h5, 0, 0, 0, 0, 0,  1, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 0,  1, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0);
        // fill, refused fifth push, drain in order, wrap
        add(0, 1, 1, 4'h1, 0, 0, 0, 0, 0,  1, 0, 0);
        add(0, 1, 1, 4'h2, 0, 0, 0, 0, 0,  2, 0, 0);
        add(0, 1, 1, 4'h3, 0, 0, 0, 0, 0,  3, 0, 0);
        add(0, 1, 1, 4'h4, 0, 0, 0, 0, 0,  4, 0, 0);
        add(0, 1, 1, 4'h9, 0, 0, 0, 0, 0,  4, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0,  3, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0,  2, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0,  1, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0);
        add(0, 1, 2, 4'hA, 0, 0, 0, 0, 0,  1, 0, 0);
        add(0, 1, 2, 4'hB, 0, 0, 0, 0, 0,  2, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0,  1, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0);
        // simultaneous push/pop at count=2, then at full
        add(0, 1, 3, 4'h3, 0, 0, 0, 0, 0,  1, 0, 0);
        add(0, 1, 3, 4'h5, 0, 0, 0, 0, 0,  2, 0, 0);
        add(0, 1, 3, 4'h7, 0, 0, 0, 1, 0,  2, 0, 0);
        add(0, 1, 4, 4'h8, 0, 0, 0, 0, 0,  3, 0, 0);
        add(0, 1, 4, 4'h9, 0, 0, 0, 0, 0,  4, 0, 0);
        add(0, 1, 4, 4'h6, 0, 0, 0, 1, 0,  3, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0,  2, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0,  1, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 0,  0, 0, 0);
        // sticky flags, clear coinciding with a setting push
        add(0, 1, 5, 4'h1, 1, 0, 0, 0, 0,  1, 1, 0);
        add(0, 1, 5, 4'h2, 0, 0, 1, 1, 0,  1, 1, 1);
        add(0, 1, 6, 4'h3, 1, 0, 0, 1, 1,  1, 1, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 1, 1,  0, 0, 0);
        // reset mid-traffic with coincident push and pop
        add(0, 1, 7, 4'h1, 1, 0, 0, 0, 0,  1, 1, 0);
        add(0, 1, 7, 4'h2, 0, 0, 0, 0, 0,  2, 1, 0);
        add(0, 1, 7, 4'h3, 0, 0, 0, 0, 0,  3, 1, 0);
        add(1, 1, 7, 4'hF, 1, 0, 1, 1, 0,  0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 0,  0, 0, 0);
        // zero check: s=0 with zero flag wrongly 0
        add(0, 1, 0, 4'h0, 0, 0, 0, 0, 0,  1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].iv, vecs[i].op, vecs[i].s, vecs[i].c,
                 vecs[i].z, vecs[i].ov, vecs[i].ordy, vecs[i].clr);
            check($sformatf("vec%0d_count", i), {{(32-CW){1'b0}}, count}, vecs[i].exp_cnt);
            check($sformatf("vec%0d_sticky_c", i), {31'd0, sticky_c}, {31'd0, vecs[i].exp_sc});
            check($sformatf("vec%0d_sticky_ov", i), {31'd0, sticky_ov}, {31'd0, vecs[i].exp_sov});
        end

        // Hand-checked zero-check outcome of the last row.
        check("zm_after_zero_push", {31'd0, zero_mismatch}, {31'd0, ZCHK});
        check("head_zero_stored", {31'd0, bus.out_zero}, {31'd0, ZCHK});
        step(0, 0, 0, 4'h0, 0, 0, 0, 1, 0);
        check("zero_drained", {{(32-CW){1'b0}}, count}, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rs = 4'($urandom_range(0, 15));
            rz = (rs == 4'd0);
            if ($urandom_range(0, 7) == 0) rz = ~rz;
            step($urandom_range(0, 99) == 0,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rs,
                 1'($urandom_range(0, 1)), rz, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        // Drain whatever is left so every pushed entry gets compared.
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 4'h0, 0, 0, 0, 1, 0);
        check("final_empty", {31'd0, bus.out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the 4-bit ALU top. Captures each ALU result (sum, carry, zero, overflow, op code) into a small FIFO and presents it to the consumer (display/register file) over a valid/ready handshake.
- Also keeps sticky carry/overflow flags for status display.
- Decouples the combinational ALU from a consumer that may stall.

Parameters:
- WIDTH, 4, data width of ALU result; matches ALU operand width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  ALU result on in_* is valid this cycle.
- in_ready  output  1  stage can accept; equals !full.
- in_op  input  3  ALU select code that produced the result.
- in_s  input  WIDTH  ALU result.
- in_c  input  1  ALU carry/borrow.
- in_zero  input  1  ALU zero flag.
- in_overflow  input  1  ALU signed overflow flag.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  consumer accepts head this cycle.
- out_op  output  3  head op code.
- out_s  output  WIDTH  head result.
- out_c  output  1  head carry.
- out_zero  output  1  head zero.
- out_overflow  output  1  head overflow.
- count  output  $clog2(DEPTH+1)  occupancy, 0..DEPTH.
- clr_sticky  input  1  clear sticky flags.
- sticky_c  output  1  set if any accepted entry had carry.
- sticky_ov  output  1  set if any accepted entry had overflow.
- zero_mismatch  output  1  see Optional Feature.

Behaviour:
- Push = in_valid && in_ready. Pop = out_valid && out_ready. Both evaluated on the same edge.
- Storage is a circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits. Pointers wrap DEPTH-1 -> 0. count tracks occupancy explicitly.
- in_ready = (count != DEPTH). Purely from registered count; no combinational path from out_ready.
  - When full, push is refused even if a pop occurs the same cycle.
- out_valid = (count != 0). out_* are driven from storage[rd_ptr].
  - out_* hold stable while out_valid && !out_ready.
  - out_* are don't-care when empty. Implementation drives the last read slot; the bench must not check them.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N (one cycle). There is no same-cycle bypass when empty.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop (not full, not empty): unchanged, both pointers advance
  - neither: unchanged
- Empty with push and out_ready=1: no pop that cycle, because out_valid was 0.
- Sticky flags:
  - On push, sticky_c |= in_c and sticky_ov |= in_overflow.
  - clr_sticky=1 clears them. If clr_sticky and a setting push coincide, the set wins (value = new flag).
- Reset (synchronous, rst=1 at edge):
  - count=0, wr_ptr=rd_ptr=0.
  - out_valid=0, in_ready=1.
  - sticky_c=0, sticky_ov=0, zero_mismatch=0.
  - Storage contents are not reset.
  - rst mid-traffic discards all entries. A push and a pop coincident with rst are ignored.
- The op code is stored verbatim. No decode beyond the optional feature.

Optional Feature:
- Macro: ALU_RESULT_ZERO_CHECK_EN.
- Defined:
  - On each push, the block recomputes z = (in_s == 0).
  - If z != in_zero, zero_mismatch is set sticky.
  - Cleared by rst or clr_sticky; a set on the same cycle wins.
  - The stored out_zero uses the recomputed z, not in_zero.
- Undefined:
  - zero_mismatch is tied to 0.
  - out_zero stores in_zero unmodified.
  - No comparator logic is generated.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then release -> count=0, out_valid=0, in_ready=1, sticky_c=0, sticky_ov=0.
2. Single transfer: push op=0, s=4'h5, c=0, zero=0, ov=0 with out_ready=0 -> next cycle out_valid=1, out_s=5, count=1. Assert out_ready one cycle -> count=0, out_valid=0.
3. Fill and wrap:
   - Push s=1,2,3,4 with out_ready=0 -> count=4, in_ready=0.
   - A fifth push with s=9 is refused.
   - Pop all -> order 1,2,3,4.
   - Push s=A,B and pop -> A,B, with pointers wrapped.
4. Simultaneous push/pop:
   - At count=2, push s=7 and pop in the same cycle -> count stays 2 and head advances.
   - At count=4 (full), in_valid and out_ready both 1 -> only the pop occurs, count=3.
5. Sticky flags: push c=1, ov=0 then c=0, ov=1 -> sticky_c=1, sticky_ov=1. Assert clr_sticky together with a push of c=1, ov=0 -> sticky_c=1, sticky_ov=0.
6. Reset mid-traffic and zero check:
   - At count=3, rst=1 for one cycle -> count=0, out_valid=0.
   - With ALU_RESULT_ZERO_CHECK_EN defined, push s=0, zero=0 -> zero_mismatch=1 and the stored out_zero=1.
   - Without the macro: zero_mismatch=0 and out_zero=0.
